// File: rtl/pps_pkg.sv
// Shared types, board defaults and helpers for the PPS discipline monitor.
// Defaults describe the 10 MHz board; simulation overrides them per instance.
package pps_pkg;

    typedef enum logic [1:0] {
        NO_PPS  = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } pps_state_t;

    localparam int DEF_CLOCK_PER_SECOND = 10_000_000;
    localparam int DEF_CNT_W            = 32;
    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_TOL              = 100;
    localparam int DEF_LOCK_COUNT       = 4;

    // True when |e| <= tol; operands are widened so any CNT_W fits.
    function automatic logic within_tol(input longint e, input longint tol);
        longint mag;
        mag = (e < 0) ? -e : e;
        return (mag <= tol);
    endfunction

endpackage

// File: rtl/pps_discipline_monitor_sync.sv
// Metastability synchroniser for the asynchronous pps pin plus a rising-edge
// detector; pps_edge is a single-cycle pulse after the synchroniser.
module pps_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pps,
    output logic pps_edge
);

    if (SYNC_STAGES < 2) begin : g_chk_stages
        $error("pps_sync_edge: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pps};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign pps_edge = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/pps_discipline_monitor.sv
// Measures clk cycles between GPS 1PPS edges, reports signed frequency error
// once per accepted second and tracks lock / loss-of-PPS status.
module pps_discipline_monitor
    import pps_pkg::*;
#(
    parameter int CLOCK_PER_SECOND = DEF_CLOCK_PER_SECOND,
    parameter int CNT_W            = DEF_CNT_W,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int TOL              = DEF_TOL,
    parameter int LOCK_COUNT       = DEF_LOCK_COUNT,
    parameter int TIMEOUT_CYCLES   = CLOCK_PER_SECOND + CLOCK_PER_SECOND / 4,
    parameter int MIN_CYCLES       = CLOCK_PER_SECOND - CLOCK_PER_SECOND / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pps,
    output logic [CNT_W-1:0]        period,
    output logic signed [CNT_W-1:0] err,
    output logic                    err_valid,
    output logic                    locked,
    output logic                    pps_missing,
    output logic [31:0]             sec_count
);

    if ((longint'(TIMEOUT_CYCLES) >= (longint'(1) << (CNT_W - 1))) ||
        (MIN_CYCLES >= CLOCK_PER_SECOND) ||
        (CLOCK_PER_SECOND >= TIMEOUT_CYCLES)) begin : g_chk_params
        $error("pps_discipline_monitor: inconsistent timing parameters");
    end

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_CYCLES);
    localparam logic [CNT_W-1:0]  CPS_C     = CNT_W'(CLOCK_PER_SECOND);
    localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);

    logic pps_edge;

    pps_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .pps     (pps),
        .pps_edge(pps_edge)
    );

    pps_state_t              state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [CNT_W-1:0]        period_reg, period_next;
    logic signed [CNT_W-1:0] err_reg, err_next;
    logic                    err_valid_reg, err_valid_next;
    logic                    locked_reg, locked_next;
    logic                    missing_reg, missing_next;
    logic [31:0]             sec_reg, sec_next;
    logic [GOOD_W-1:0]       good_reg, good_next;
    logic [GOOD_W-1:0]       good_upd;

    // The edge being evaluated closes a period of cnt+1 cycles.
    logic [CNT_W-1:0]        meas;
    logic signed [CNT_W-1:0] err_calc;
    logic                    meas_good;
    logic                    runt;
    logic                    timeout_hit;

    assign meas        = cnt_reg + CNT_W'(1);
    assign err_calc    = signed'(meas - CPS_C);
    assign meas_good   = within_tol(64'(err_calc), longint'(TOL));
    assign runt        = (meas < MIN_C);
    assign timeout_hit = (cnt_reg == TIMEOUT_C - CNT_W'(1));

    always_comb begin
        state_next     = state_reg;
        cnt_next       = (cnt_reg == TIMEOUT_C) ? cnt_reg : cnt_reg + CNT_W'(1);
        period_next    = period_reg;
        err_next       = err_reg;
        err_valid_next = 1'b0;
        locked_next    = locked_reg;
        missing_next   = missing_reg;
        sec_next       = sec_reg;
        good_next      = good_reg;
        good_upd       = meas_good ? good_reg + GOOD_W'(1) : '0;

        if (state_reg == NO_PPS) begin
            if (pps_edge) begin
                state_next   = ACQUIRE;
                cnt_next     = '0;
                missing_next = 1'b0;
            end
        end else if (pps_edge && !runt) begin
            cnt_next       = '0;
            period_next    = meas;
            err_next       = err_calc;
            err_valid_next = 1'b1;
            case (state_reg)
                ACQUIRE: begin
                    good_next  = meas_good ? GOOD_W'(1) : '0;
                    sec_next   = 32'd1;
                    state_next = TRACK;
                end
                TRACK: begin
                    good_next = good_upd;
                    sec_next  = sec_reg + 32'd1;
                    if (good_upd == LOCK_C) begin
                        state_next  = LOCKED;
                        locked_next = 1'b1;
                    end
                end
                default: begin
                    sec_next = sec_reg + 32'd1;
                    if (!meas_good) begin
                        good_next   = '0;
                        locked_next = 1'b0;
                        state_next  = TRACK;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            // Edge-less for too long: period/err deliberately keep last values.
            state_next   = NO_PPS;
            missing_next = 1'b1;
            locked_next  = 1'b0;
            good_next    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= NO_PPS;
            cnt_reg       <= '0;
            period_reg    <= '0;
            err_reg       <= '0;
            err_valid_reg <= 1'b0;
            locked_reg    <= 1'b0;
            missing_reg   <= 1'b1;
            sec_reg       <= '0;
            good_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            period_reg    <= period_next;
            err_reg       <= err_next;
            err_valid_reg <= err_valid_next;
            locked_reg    <= locked_next;
            missing_reg   <= missing_next;
            sec_reg       <= sec_next;
            good_reg      <= good_next;
        end
    end

    assign period      = period_reg;
    assign err         = err_reg;
    assign err_valid   = err_valid_reg;
    assign locked      = locked_reg;
    assign pps_missing = missing_reg;
    assign sec_count   = sec_reg;

endmodule

// File: doc/pps_discipline_monitor.md
Name: pps_discipline_monitor

Overview:
- Parametrised successor to the single-rate PPS clock counter.
- Measures local clock cycles between GPS 1PPS rising edges and reports signed frequency error per second.
- Adds input synchronisation, runt-pulse rejection, missing-PPS timeout, a lock state machine and a seconds counter.
- Sits between the PMod GPS pps pin and the status LEDs / UART reporting logic.

Parameters:
- CLOCK_PER_SECOND, 10_000_000, nominal clk cycles per PPS period.
- CNT_W, 32, width of cycle counter, period and error outputs.
- SYNC_STAGES, 2, flops in the pps synchroniser (≥2).
- TOL, 100, max |err| in cycles for a second to count as good.
- LOCK_COUNT, 4, consecutive good seconds required to assert locked.
- TIMEOUT_CYCLES, CLOCK_PER_SECOND + CLOCK_PER_SECOND/4, cycles without an edge before declaring PPS lost.
- MIN_CYCLES, CLOCK_PER_SECOND - CLOCK_PER_SECOND/8, periods shorter than this are runts and are ignored.
- Elaboration check: TIMEOUT_CYCLES < 2^(CNT_W-1); MIN_CYCLES < CLOCK_PER_SECOND < TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- pps  in  1  asynchronous 1PPS from GPS module.
- period  out  CNT_W  last accepted period in cycles.
- err  out  CNT_W signed  period - CLOCK_PER_SECOND for last accepted period.
- err_valid  out  1  one-cycle strobe when period/err update.
- locked  out  1  high in LOCKED state.
- pps_missing  out  1  high in NO_PPS state.
- sec_count  out  32  accepted edges since last entry to TRACK from ACQUIRE; wraps modulo 2^32.

Behaviour:
- Reset (rst_n=0 at posedge clk): state=NO_PPS, cnt=0, sync flops=0, period=0, err=0, err_valid=0, locked=0, pps_missing=1, sec_count=0, good=0.
- Synchroniser: SYNC_STAGES flops, then one flop for edge detection. edge=1 for one cycle, SYNC_STAGES+1 cycles after pps rises (setup met).
- cnt clears to 0 on every accepted edge and otherwise increments, saturating at TIMEOUT_CYCLES. Measured period = cnt+1, so edges exactly CLOCK_PER_SECOND cycles apart give period=CLOCK_PER_SECOND, err=0.
- Runt rule: in ACQUIRE/TRACK/LOCKED an edge with cnt+1 < MIN_CYCLES is ignored (cnt keeps counting, no strobe). In NO_PPS every edge is accepted.
- NO_PPS:
  - On edge: go to ACQUIRE; cnt=0; pps_missing=0.
  - No err_valid is produced.
- ACQUIRE:
  - On accepted edge: latch period/err and pulse err_valid next cycle.
  - good = (|err|≤TOL) ? 1 : 0; sec_count=1; go to TRACK.
- TRACK, on accepted edge:
  - Latch period/err, pulse err_valid, sec_count+1.
  - If good: good+1, else good=0.
  - When updated good reaches LOCK_COUNT: go to LOCKED; locked=1 the same cycle err_valid is high.
- LOCKED, on accepted edge:
  - Latch period/err, pulse err_valid, sec_count+1.
  - If bad: good=0, locked=0, go to TRACK.
- Timeout: in ACQUIRE/TRACK/LOCKED, when cnt reaches TIMEOUT_CYCLES-1 with no edge that cycle: go to NO_PPS; pps_missing=1, locked=0, good=0, no err_valid. period/err hold their last values.
- Edge and timeout in the same cycle: edge wins.
- Outputs are registered. err_valid is high exactly one cycle per accepted edge outside NO_PPS/ACQUIRE-entry; period/err are stable until the next strobe.
- Reset asserted mid-measurement discards the partial count. Behaviour after reset is identical to power-up.

Decomposition:
- Package pps_pkg holds:
  - state enum (NO_PPS, ACQUIRE, TRACK, LOCKED);
  - the abs/tolerance helper function;
  - default localparams for the 10 MHz board.
- Sub-module pps_sync_edge(clk, rst_n, pps, edge), parametrised by SYNC_STAGES.
- The top module holds the counter, the state machine and the output registers.

Test Plan (sim params CLOCK_PER_SECOND=100, TOL=2, LOCK_COUNT=3, TIMEOUT_CYCLES=125, MIN_CYCLES=88, SYNC_STAGES=2):
- Reset then pps edges every 100 cycles ×5 -> err_valid on edges 2-5, err=0, period=100, locked rises with edge 4's strobe, sec_count=4.
- Locked, then one period of 103 -> err=+3, locked drops same cycle, state TRACK; three further 100-cycle periods relock.
- Periods 99,101,98 -> err=-1,+1,-2, all good, lock after third.
- Locked, extra pps pulse 40 cycles after an edge -> no strobe, next real edge at 100 gives period=100, err=0.
- Locked, pps stops -> pps_missing=1 and locked=0 exactly 125 cycles after the last edge was detected; next edge -> ACQUIRE with no strobe.
- rst_n low for 1 cycle mid-period while locked -> all outputs return to reset values; first post-reset edge gives no err_valid.
